// File: rtl/voice_allocator_pkg.sv
// Shared configuration defaults and per-voice state type for the voice allocator.
package voice_allocator_pkg;

    localparam int DEFAULT_NUM_VOICES = 8;
    localparam int DEFAULT_NOTE_WIDTH = 7;
    localparam int DEFAULT_VEL_WIDTH  = 7;

    // Lifecycle of one voice: assigned by note on, released by note off,
    // returned to the pool when its envelope finishes.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        RELEASING = 2'd2
    } voice_state_t;

endpackage

// File: rtl/voice_select.sv
// Combinational voice search: note match, first free voice and steal candidate.
module voice_select
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
    parameter int AGE_WIDTH  = $clog2(NUM_VOICES) + 1
) (
    input  voice_state_t            state [NUM_VOICES],
    input  logic [NOTE_WIDTH-1:0]   note  [NUM_VOICES],
    input  logic [AGE_WIDTH-1:0]    age   [NUM_VOICES],
    input  logic [NOTE_WIDTH-1:0]   midi_note,
    output logic [NUM_VOICES-1:0]   match,
    output logic [NUM_VOICES-1:0]   free,
    output logic [NUM_VOICES-1:0]   steal
);

    logic                  found_match;
    logic                  found_free;
    logic                  found_rel;
    logic                  found_held;
    logic [AGE_WIDTH-1:0]  rel_age;
    logic [AGE_WIDTH-1:0]  held_age;
    logic [NUM_VOICES-1:0] rel_pick;
    logic [NUM_VOICES-1:0] held_pick;

    // Lowest-index one-hot picks; strict '>' on age keeps the lowest index on ties.
    always_comb begin
        match       = '0;
        free        = '0;
        steal       = '0;
        found_match = 1'b0;
        found_free  = 1'b0;
        found_rel   = 1'b0;
        found_held  = 1'b0;
        rel_age     = '0;
        held_age    = '0;
        rel_pick    = '0;
        held_pick   = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!found_match && state[i] != IDLE && note[i] == midi_note) begin
                match[i]    = 1'b1;
                found_match = 1'b1;
            end
            if (!found_free && state[i] == IDLE) begin
                free[i]    = 1'b1;
                found_free = 1'b1;
            end
            if (state[i] == RELEASING && (!found_rel || age[i] > rel_age)) begin
                rel_pick    = '0;
                rel_pick[i] = 1'b1;
                rel_age     = age[i];
                found_rel   = 1'b1;
            end
            if (state[i] == HELD && (!found_held || age[i] > held_age)) begin
                held_pick    = '0;
                held_pick[i] = 1'b1;
                held_age     = age[i];
                found_held   = 1'b1;
            end
        end
        steal = found_rel ? rel_pick : held_pick;
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice manager: maps MIDI note events onto envelope voices,
// stealing the oldest voice when the pool is exhausted.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
    parameter int VEL_WIDTH  = DEFAULT_VEL_WIDTH,
    parameter int AGE_WIDTH  = $clog2(NUM_VOICES) + 1
) (
    input  logic                             clock_50_000_000,
    input  logic                             reset_l,
    input  logic                             midi_valid,
    input  logic                             midi_note_on,
    input  logic [NOTE_WIDTH-1:0]            midi_note,
    input  logic [VEL_WIDTH-1:0]             midi_velocity,
    output logic                             midi_ready,
    input  logic [NUM_VOICES-1:0]            voice_envelope_end,
    output logic [NUM_VOICES-1:0]            voice_note_on,
    output logic [NUM_VOICES-1:0]            voice_note_off,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]            voice_active
);

    voice_state_t          state  [NUM_VOICES];
    logic [NOTE_WIDTH-1:0] note_q [NUM_VOICES];
    logic [VEL_WIDTH-1:0]  vel_q  [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  age    [NUM_VOICES];

    logic [NUM_VOICES-1:0] match;
    logic [NUM_VOICES-1:0] free;
    logic [NUM_VOICES-1:0] steal;
    logic [NUM_VOICES-1:0] chosen;
    logic [NUM_VOICES-1:0] release_hit;
    logic [NUM_VOICES-1:0] end_hit;
    logic                  accept;
    logic                  note_on_evt;
    logic                  note_off_evt;

    // Zero-velocity note on is a note off.
    assign accept       = midi_valid && midi_ready;
    assign note_on_evt  = accept && midi_note_on && (midi_velocity != '0);
    assign note_off_evt = accept && !note_on_evt;

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .NOTE_WIDTH (NOTE_WIDTH),
        .AGE_WIDTH  (AGE_WIDTH)
    ) u_select (
        .state     (state),
        .note      (note_q),
        .age       (age),
        .midi_note (midi_note),
        .match     (match),
        .free      (free),
        .steal     (steal)
    );

    // Pick the note-on target by priority and flag per-voice release / end hits.
    always_comb begin
        chosen      = '0;
        release_hit = '0;
        end_hit     = '0;
        if (match != '0) begin
            chosen = match;
        end else if (free != '0) begin
            chosen = free;
        end else begin
            chosen = steal;
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            release_hit[i] = (state[i] == HELD) && (note_q[i] == midi_note);
            end_hit[i]     = voice_envelope_end[i] && (state[i] == RELEASING);
        end
    end

    // Ready handshake and one-cycle envelope pulses.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            midi_ready     <= 1'b0;
            voice_note_on  <= '0;
            voice_note_off <= '0;
        end else begin
            midi_ready     <= 1'b1;
            voice_note_on  <= note_on_evt ? chosen : '0;
            voice_note_off <= note_off_evt ? release_hit : '0;
        end
    end

    // Per-voice state, assignment and age; note on takes precedence over envelope end.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                state[i]  <= IDLE;
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (note_on_evt && chosen[i]) begin
                    state[i]  <= HELD;
                    note_q[i] <= midi_note;
                    vel_q[i]  <= midi_velocity;
                    age[i]    <= '0;
                end else if (end_hit[i]) begin
                    state[i] <= IDLE;
                    age[i]   <= '0;
                end else begin
                    if (note_on_evt && state[i] != IDLE && age[i] != '1) begin
                        age[i] <= age[i] + 1'b1;
                    end
                    if (note_off_evt && release_hit[i]) begin
                        state[i] <= RELEASING;
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_out
            assign voice_note[g*NOTE_WIDTH +: NOTE_WIDTH]  = note_q[g];
            assign voice_velocity[g*VEL_WIDTH +: VEL_WIDTH] = vel_q[g];
            assign voice_active[g]                          = (state[g] != IDLE);
        end
    endgenerate

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus randomized
// traffic compared every cycle against a behavioural voice-pool model.
module tb_voice_allocator;

    localparam int NV      = 8;
    localparam int NW      = 7;
    localparam int VW      = 7;
    localparam int AGE_MAX = 15;
    localparam int ST_IDLE = 0;
    localparam int ST_HELD = 1;
    localparam int ST_REL  = 2;

    logic              clk = 1'b0;
    logic              reset_l = 1'b1;
    logic              midi_valid = 1'b0;
    logic              midi_note_on = 1'b0;
    logic [NW-1:0]     midi_note = '0;
    logic [VW-1:0]     midi_velocity = '0;
    logic              midi_ready;
    logic [NV-1:0]     voice_envelope_end = '0;
    logic [NV-1:0]     voice_note_on;
    logic [NV-1:0]     voice_note_off;
    logic [NV*NW-1:0]  voice_note;
    logic [NV*VW-1:0]  voice_velocity;
    logic [NV-1:0]     voice_active;

    voice_allocator #(
        .NUM_VOICES (NV),
        .NOTE_WIDTH (NW),
        .VEL_WIDTH  (VW)
    ) dut (
        .clock_50_000_000   (clk),
        .reset_l            (reset_l),
        .midi_valid         (midi_valid),
        .midi_note_on       (midi_note_on),
        .midi_note          (midi_note),
        .midi_velocity      (midi_velocity),
        .midi_ready         (midi_ready),
        .voice_envelope_end (voice_envelope_end),
        .voice_note_on      (voice_note_on),
        .voice_note_off     (voice_note_off),
        .voice_note         (voice_note),
        .voice_velocity     (voice_velocity),
        .voice_active       (voice_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model of the voice pool.
    int          m_state [NV];
    int          m_age   [NV];
    logic [NW-1:0] m_note [NV];
    logic [VW-1:0] m_vel  [NV];
    bit          m_on    [NV];
    bit          m_off   [NV];
    bit          m_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        for (int i = 0; i < NV; i++) begin
            m_state[i] = ST_IDLE;
            m_age[i]   = 0;
            m_note[i]  = '0;
            m_vel[i]   = '0;
            m_on[i]    = 1'b0;
            m_off[i]   = 1'b0;
        end
    endtask

    function automatic int oldest(input int s);
        int best = -1;
        int best_age = -1;
        for (int i = 0; i < NV; i++) begin
            if (m_state[i] == s && m_age[i] > best_age) begin
                best = i;
                best_age = m_age[i];
            end
        end
        return best;
    endfunction

    // Advance the model by one clock edge using the inputs present before the edge.
    task automatic model_step();
        bit end_now [NV];
        bit accept;
        int c;
        if (!reset_l) begin
            model_reset();
            return;
        end
        accept  = midi_valid && m_ready;
        m_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            m_on[i]    = 1'b0;
            m_off[i]   = 1'b0;
            end_now[i] = voice_envelope_end[i] && (m_state[i] == ST_REL);
        end
        c = -1;
        if (accept && midi_note_on && midi_velocity != 0) begin
            for (int i = 0; i < NV; i++)
                if (c < 0 && m_state[i] != ST_IDLE && m_note[i] == midi_note) c = i;
            for (int i = 0; i < NV; i++)
                if (c < 0 && m_state[i] == ST_IDLE) c = i;
            if (c < 0) c = oldest(ST_REL);
            if (c < 0) c = oldest(ST_HELD);
            for (int i = 0; i < NV; i++) begin
                if (i == c) begin
                    m_state[i] = ST_HELD;
                    m_note[i]  = midi_note;
                    m_vel[i]   = midi_velocity;
                    m_age[i]   = 0;
                    m_on[i]    = 1'b1;
                end else if (m_state[i] != ST_IDLE) begin
                    m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < NV; i++) begin
                if (m_state[i] == ST_HELD && m_note[i] == midi_note) begin
                    m_state[i] = ST_REL;
                    m_off[i]   = 1'b1;
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (end_now[i] && i != c) begin
                m_state[i] = ST_IDLE;
                m_age[i]   = 0;
            end
        end
    endtask

    function automatic logic [NV-1:0] pack_bits(input int which);
        logic [NV-1:0] v = '0;
        for (int i = 0; i < NV; i++) begin
            case (which)
                0:       v[i] = m_on[i];
                1:       v[i] = m_off[i];
                default: v[i] = (m_state[i] != ST_IDLE);
            endcase
        end
        return v;
    endfunction

    function automatic logic [NV*NW-1:0] pack_notes();
        logic [NV*NW-1:0] v = '0;
        for (int i = 0; i < NV; i++) v[i*NW +: NW] = m_note[i];
        return v;
    endfunction

    function automatic logic [NV*VW-1:0] pack_vels();
        logic [NV*VW-1:0] v = '0;
        for (int i = 0; i < NV; i++) v[i*VW +: VW] = m_vel[i];
        return v;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready",    64'(midi_ready),     64'(m_ready));
            check("note_on",  64'(voice_note_on),  64'(pack_bits(0)));
            check("note_off", 64'(voice_note_off), 64'(pack_bits(1)));
            check("active",   64'(voice_active),   64'(pack_bits(2)));
            check("notes",    64'(voice_note),     64'(pack_notes()));
            check("vels",     64'(voice_velocity), 64'(pack_vels()));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input bit on, input int note, input int vel, input logic [NV-1:0] env);
        midi_valid         = 1'b1;
        midi_note_on       = on;
        midi_note          = NW'(note);
        midi_velocity      = VW'(vel);
        voice_envelope_end = env;
        tick();
        midi_valid         = 1'b0;
        voice_envelope_end = '0;
    endtask

    initial begin
        model_reset();
        #1 reset_l = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("ready_in_reset", 64'(midi_ready), 64'd0);
        reset_l = 1'b1;
        #1 check("ready_before_edge", 64'(midi_ready), 64'd0);
        tick();
        check("ready_after_edge", 64'(midi_ready), 64'd1);

        // Two note ons into the first two voices.
        send(1, 60, 100, '0);
        check("on_60", 64'(voice_note_on), 64'h01);
        check("note0_60", 64'(voice_note[NW-1:0]), 64'd60);
        send(1, 64, 80, '0);
        check("on_64", 64'(voice_note_on), 64'h02);
        check("note1_64", 64'(voice_note[2*NW-1:NW]), 64'd64);
        check("active_03", 64'(voice_active), 64'h03);

        // Release 60, finish its envelope, then reuse voice 0.
        send(0, 60, 0, '0);
        check("off_60", 64'(voice_note_off), 64'h01);
        tick();
        check("off_once", 64'(voice_note_off), 64'h00);
        for (int i = 0; i < 3; i++) tick();
        voice_envelope_end = 8'h01;
        tick();
        voice_envelope_end = '0;
        check("active_after_end", 64'(voice_active), 64'h02);
        send(1, 67, 90, '0);
        check("reuse_v0", 64'(voice_note_on), 64'h01);
        check("note0_67", 64'(voice_note[NW-1:0]), 64'd67);
        send(1, 65, 50, '0);

        // Asynchronous reset with three held voices.
        #2 reset_l = 1'b0;
        model_reset();
        #1;
        check("rst_active", 64'(voice_active), 64'd0);
        check("rst_ready",  64'(midi_ready),   64'd0);
        check("rst_notes",  64'(voice_note),   64'd0);
        check("rst_vels",   64'(voice_velocity), 64'd0);
        tick();
        tick();
        reset_l = 1'b1;
        #1 check("rel_ready_low", 64'(midi_ready), 64'd0);
        tick();
        check("rel_ready_high", 64'(midi_ready), 64'd1);

        // Fill all voices, release 67, then steal the releasing voice.
        for (int n = 60; n < 68; n++) send(1, n, 20 + n, '0);
        check("all_active", 64'(voice_active), 64'hFF);
        send(0, 67, 0, '0);
        check("off_67", 64'(voice_note_off), 64'h80);
        send(1, 70, 33, '0);
        check("steal_rel", 64'(voice_note_on), 64'h80);
        check("note7_70", 64'(voice_note[8*NW-1:7*NW]), 64'd70);

        // All held: oldest held voice 0 is stolen.
        send(1, 72, 10, '0);
        check("steal_held", 64'(voice_note_on), 64'h01);
        check("note0_72", 64'(voice_note[NW-1:0]), 64'd72);
        send(1, 60, 0, '0);
        check("vel0_no_on",  64'(voice_note_on),  64'h00);
        check("vel0_no_off", 64'(voice_note_off), 64'h00);
        check("vel0_note0",  64'(voice_note[NW-1:0]), 64'd72);
        check("vel0_active", 64'(voice_active), 64'hFF);

        // Note on and envelope end hit voice 2 in the same cycle.
        send(0, 62, 0, '0);
        check("off_62", 64'(voice_note_off), 64'h04);
        send(1, 62, 50, 8'h04);
        check("on_wins", 64'(voice_note_on), 64'h04);
        check("on_wins_active", 64'(voice_active), 64'hFF);
        send(1, 62, 99, '0);
        check("retrigger", 64'(voice_note_on), 64'h04);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            midi_valid         = ($urandom_range(0, 1) == 1);
            midi_note_on       = ($urandom_range(0, 9) < 6);
            midi_note          = NW'($urandom_range(60, 71));
            midi_velocity      = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom_range(1, 127));
            voice_envelope_end = NV'($urandom) & NV'($urandom);
            tick();
        end
        midi_valid         = 1'b0;
        voice_envelope_end = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
